// File: rtl/jkc_pkg.sv
// ---------------------------------------------------------------------------
// jkc_pkg
// Shared definitions for the JK-cell based up/down counter.
//   - DIR_UP / DIR_DN : direction encodings for the 'up' input
//   - jk_cmd_t        : 2-bit JK command {J,K} driven into each jk_cell
//   - params_ok()     : legality check for the WIDTH/MODULUS combination
//   - force_cmd()     : JK command that forces a cell to a given bit value
// No ports (package).
// ---------------------------------------------------------------------------
package jkc_pkg;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  localparam int WIDTH_MIN = 32'sd2;
  localparam int WIDTH_MAX = 32'sd16;

  // Encoding is {J,K}: 01 resets the cell, 10 sets it, 11 toggles it.
  typedef enum logic [1:0] {
    JK_HOLD = 2'b00,
    JK_RST  = 2'b01,
    JK_SET  = 2'b10,
    JK_TGL  = 2'b11
  } jk_cmd_t;

  // Width must lie in 2..16 and the modulus must fit in the count range.
  function automatic bit params_ok(input int width, input int modulus);
    bit ok;
    ok = (width >= WIDTH_MIN) && (width <= WIDTH_MAX) &&
         (modulus >= 32'sd2) && (modulus <= (32'sd1 << width));
    return ok;
  endfunction

  // Direct set/reset command that drives a cell to the requested value.
  function automatic jk_cmd_t force_cmd(input logic bit_val);
    jk_cmd_t cmd;
    if (bit_val) begin
      cmd = JK_SET;
    end else begin
      cmd = JK_RST;
    end
    return cmd;
  endfunction

endpackage

// File: rtl/jk_cell.sv
// ---------------------------------------------------------------------------
// jk_cell
// One state bit of the counter, implemented as a JK flip-flop.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high clear
//   cmd  : JK command {J,K} (hold / reset / set / toggle)
//   q    : registered cell output
// ---------------------------------------------------------------------------
module jk_cell
  import jkc_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  jk_cmd_t cmd,
  output logic    q
);

  // JK flip-flop state update with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= 1'b0;
    end else begin
      case (cmd)
        JK_HOLD: q <= q;
        JK_RST:  q <= 1'b0;
        JK_SET:  q <= 1'b1;
        JK_TGL:  q <= ~q;
        default: q <= q;
      endcase
    end
  end

endmodule

// File: rtl/jk_updown_counter_chk.sv
// ---------------------------------------------------------------------------
// jk_updown_counter_chk
// Property checker for jk_updown_counter; observes the counter's ports only.
// Ports:
//   clk, rst             : counter clock and asynchronous reset
//   en, load             : counter controls
//   q, tc, wrap          : counter outputs
// Properties:
//   - q never leaves the range 0..MODULUS-1
//   - wrap only follows an edge where the counter was enabled, not loading,
//     and sitting at its terminal count
// ---------------------------------------------------------------------------
module jk_updown_counter_chk #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input logic             clk,
  input logic             rst,
  input logic             en,
  input logic             load,
  input logic [WIDTH-1:0] q,
  input logic             tc,
  input logic             wrap
);

  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);

  // Count stays inside the modulus.
  q_in_range: assert property (@(posedge clk) disable iff (rst) q <= MAX);

  // Every wrap pulse has a counting terminal-count edge behind it.
  wrap_cause: assert property (@(posedge clk) disable iff (rst)
                               wrap |-> $past(en && !load && tc));

endmodule

// File: rtl/jk_updown_counter.sv
// ---------------------------------------------------------------------------
// jk_updown_counter
// Synchronous up/down modulo-MODULUS counter built from WIDTH JK cells.
// Normal counting drives every cell in toggle mode with a ripple-style
// toggle enable; wraps on a non-full modulus and parallel loads drive the
// cells with direct set/reset commands instead.
//
// Parameters:
//   WIDTH   : counter width, 2..16
//   MODULUS : count modulus, 2..2**WIDTH (count range 0..MODULUS-1)
// Ports:
//   clk      : rising-edge clock
//   rst      : asynchronous active-high reset (clears q, wrap, ovf)
//   en       : count enable
//   up       : direction, 1 = increment, 0 = decrement
//   load     : synchronous parallel load, priority over en
//   load_val : value to load (clamped to MODULUS-1)
//   q        : registered count
//   tc       : terminal count, combinational from q and up
//   wrap     : registered one-cycle pulse after each modulus wrap
//   ovf      : sticky wrap flag
// Build option:
//   JKC_OVF_STICKY_EN : when defined, ovf sets on each wrap and clears on
//                       load or rst; when undefined, ovf is tied to 0.
// ---------------------------------------------------------------------------
module jk_updown_counter
  import jkc_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap,
  output logic             ovf
);

  // Highest count value, truncated to the counter width.
  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);
  // A full-range modulus wraps naturally through the toggle chain.
  localparam bit FULL = (MODULUS == (32'sd1 << WIDTH));

  generate
    if (!params_ok(WIDTH, MODULUS)) begin : g_bad_params
      $error("jk_updown_counter: illegal WIDTH=%0d / MODULUS=%0d (need 2<=WIDTH<=16, 2<=MODULUS<=2**WIDTH)",
             WIDTH, MODULUS);
    end
  endgenerate

  logic             at_end;
  logic             wrap_next;
  logic [WIDTH-1:0] tgl;
  logic [WIDTH-1:0] ld_target;
  logic [WIDTH-1:0] wrap_target;
  jk_cmd_t          cmd [WIDTH];

  // Terminal count depends on direction only, never on en.
  assign at_end      = (up == DIR_UP) ? (q == MAX) : (q == {WIDTH{1'b0}});
  assign tc          = at_end;
  assign wrap_next   = en & ~load & at_end;
  assign ld_target   = (load_val > MAX) ? MAX : load_val;
  assign wrap_target = (up == DIR_UP) ? {WIDTH{1'b0}} : MAX;

  // Toggle enables: bit i toggles when all lower bits are 1 (up) or 0 (down).
  always_comb begin : p_toggle
    logic all_ones;
    logic all_zeros;
    all_ones  = 1'b1;
    all_zeros = 1'b1;
    tgl       = {WIDTH{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      if (up == DIR_UP) begin
        tgl[i] = all_ones;
      end else begin
        tgl[i] = all_zeros;
      end
      all_ones  = all_ones & q[i];
      all_zeros = all_zeros & ~q[i];
    end
  end

  // Per-cell JK command: load > count (wrap override or toggle) > hold.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      cmd[i] = JK_HOLD;
    end
    if (load) begin
      for (int i = 0; i < WIDTH; i++) begin
        cmd[i] = force_cmd(ld_target[i]);
      end
    end else if (en) begin
      if (at_end && !FULL) begin
        for (int i = 0; i < WIDTH; i++) begin
          cmd[i] = force_cmd(wrap_target[i]);
        end
      end else begin
        for (int i = 0; i < WIDTH; i++) begin
          cmd[i] = tgl[i] ? JK_TGL : JK_HOLD;
        end
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        cmd[i] = JK_HOLD;
      end
    end
  end

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      jk_cell u_cell (
        .clk (clk),
        .rst (rst),
        .cmd (cmd[i]),
        .q   (q[i])
      );
    end
  endgenerate

  // Wrap pulse register: high for the single cycle after a wrapping edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrap <= 1'b0;
    end else begin
      wrap <= wrap_next;
    end
  end

`ifdef JKC_OVF_STICKY_EN
  // Sticky overflow: load takes priority over a coincident wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (load) begin
      ovf <= 1'b0;
    end else if (wrap_next) begin
      ovf <= 1'b1;
    end else begin
      ovf <= ovf;
    end
  end
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_jk_updown_counter.sv
module tb_jk_updown_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       up;
  logic       load;
  logic [3:0] load_val;

  logic [3:0] q16, q10;
  logic       tc16, tc10, wrap16, wrap10, ovf16, ovf10;

`ifdef JKC_OVF_STICKY_EN
  localparam logic STICKY = 1'b1;
`else
  localparam logic STICKY = 1'b0;
`endif

  always #5 clk = ~clk;

  jk_updown_counter #(.WIDTH(4), .MODULUS(16)) u_dut16 (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .q(q16), .tc(tc16), .wrap(wrap16), .ovf(ovf16)
  );

  jk_updown_counter #(.WIDTH(4), .MODULUS(10)) u_dut10 (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .q(q10), .tc(tc10), .wrap(wrap10), .ovf(ovf10)
  );

  jk_updown_counter_chk #(.WIDTH(4), .MODULUS(16)) u_chk16 (
    .clk(clk), .rst(rst), .en(en), .load(load), .q(q16), .tc(tc16), .wrap(wrap16)
  );

  jk_updown_counter_chk #(.WIDTH(4), .MODULUS(10)) u_chk10 (
    .clk(clk), .rst(rst), .en(en), .load(load), .q(q10), .tc(tc10), .wrap(wrap10)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic       en;
    logic       up;
    logic       load;
    logic [3:0] load_val;
    logic       sel10;     // 1: check the MODULUS=10 instance
    logic [3:0] exp_q;
    logic       exp_wrap;
    logic       exp_tc;
  } vec_t;

  vec_t vecs [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input logic e, input logic u, input logic l, input logic [3:0] lv,
                     input logic s, input logic [3:0] eq, input logic ew, input logic et);
    vec_t v;
    v.en = e; v.up = u; v.load = l; v.load_val = lv; v.sel10 = s;
    v.exp_q = eq; v.exp_wrap = ew; v.exp_tc = et;
    vecs.push_back(v);
  endtask

  // Apply vectors lo..hi, one clock edge each, checking 1 ns after the edge.
  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      en = vecs[i].en; up = vecs[i].up; load = vecs[i].load; load_val = vecs[i].load_val;
      @(posedge clk);
      #1;
      if (vecs[i].sel10) begin
        check($sformatf("v%0d_q10", i), 32'(q10), 32'(vecs[i].exp_q));
        check($sformatf("v%0d_wrap10", i), 32'(wrap10), 32'(vecs[i].exp_wrap));
        check($sformatf("v%0d_tc10", i), 32'(tc10), 32'(vecs[i].exp_tc));
      end else begin
        check($sformatf("v%0d_q16", i), 32'(q16), 32'(vecs[i].exp_q));
        check($sformatf("v%0d_wrap16", i), 32'(wrap16), 32'(vecs[i].exp_wrap));
        check($sformatf("v%0d_tc16", i), 32'(tc16), 32'(vecs[i].exp_tc));
      end
    end
  endtask

  // One edge with the given controls, then settle 1 ns.
  task automatic step(input logic e, input logic u, input logic l, input logic [3:0] lv);
    en = e; up = u; load = l; load_val = lv;
    @(posedge clk);
    #1;
  endtask

  // Called 1 ns after an edge: 3 ns reset pulse ending on the falling edge.
  task automatic rst_pulse(input string tag);
    #1 rst = 1'b1;
    #1;
    check({tag, "_async_q16"}, 32'(q16), 32'd0);
    check({tag, "_async_wrap16"}, 32'(wrap16), 32'd0);
    check({tag, "_async_ovf16"}, 32'(ovf16), 32'd0);
    #2 rst = 1'b0;
  endtask

  int seg_a, seg_b, seg_c, seg_d, seg_end;

  initial begin
    rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_val = 4'd0;

    // Segment A: MODULUS=16, count up 17 edges from 0.
    seg_a = 0;
    for (int k = 1; k <= 17; k++) begin
      add(1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 4'(k % 16), (k == 16), ((k % 16) == 15));
    end
    // Segment B: MODULUS=10, up to 1 through one wrap, then down 1,0,9,8.
    seg_b = vecs.size();
    for (int k = 1; k <= 11; k++) begin
      add(1'b1, 1'b1, 1'b0, 4'd0, 1'b1, 4'(k % 10), (k == 10), ((k % 10) == 9));
    end
    add(1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 4'd0, 1'b0, 1'b1);
    add(1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 4'd9, 1'b1, 1'b0);
    add(1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 4'd8, 1'b0, 1'b0);
    // Segment C: loads on MODULUS=10 (clamp, boundary, load over wrap).
    seg_c = vecs.size();
    add(1'b1, 1'b1, 1'b1, 4'd13, 1'b1, 4'd9, 1'b0, 1'b1);
    add(1'b0, 1'b1, 1'b1, 4'd4,  1'b1, 4'd4, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1, 4'd10, 1'b1, 4'd9, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b1, 4'd2,  1'b1, 4'd2, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b1, 4'd9,  1'b1, 4'd9, 1'b0, 1'b1);
    // Segment D: hold at 5, then alternate direction each edge.
    seg_d = vecs.size();
    add(1'b0, 1'b1, 1'b1, 4'd5, 1'b1, 4'd5, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      add(1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 4'd5, 1'b0, 1'b0);
    end
    add(1'b1, 1'b1, 1'b0, 4'd0, 1'b1, 4'd6, 1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 4'd5, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b0, 4'd0, 1'b1, 4'd6, 1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 4'd5, 1'b0, 1'b0);
    seg_end = vecs.size();

    // Reset held for two edges.
    repeat (2) @(posedge clk);
    #1;
    check("rst_q16", 32'(q16), 32'd0);
    check("rst_q10", 32'(q10), 32'd0);
    check("rst_wrap16", 32'(wrap16), 32'd0);
    check("rst_ovf16", 32'(ovf16), 32'd0);
    check("rst_tc16", 32'(tc16), 32'd0);
    rst = 1'b0;

    run_vecs(seg_a, seg_b - 1);

    // Re-reset so the MODULUS=10 instance starts from 0.
    rst = 1'b1;
    #1;
    check("rerst_q10", 32'(q10), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    run_vecs(seg_b, seg_end - 1);

    // Async reset mid-count on MODULUS=16: 7 -> 8, reset, resume from 0.
    step(1'b0, 1'b1, 1'b1, 4'd7);
    check("mid_load7", 32'(q16), 32'd7);
    step(1'b1, 1'b1, 1'b0, 4'd0);
    check("mid_q8", 32'(q16), 32'd8);
    rst_pulse("mid");
    @(posedge clk);
    #1;
    check("mid_resume", 32'(q16), 32'd1);

    // Reset in the cycle a wrap pulse is high forces it low at once.
    step(1'b0, 1'b1, 1'b1, 4'd15);
    step(1'b1, 1'b1, 1'b0, 4'd0);
    check("wr_q0", 32'(q16), 32'd0);
    check("wr_wrap", 32'(wrap16), 32'd1);
    check("wr_ovf", 32'(ovf16), 32'(STICKY));
    rst_pulse("wr");
    @(posedge clk);
    #1;
    check("wr_resume_q", 32'(q16), 32'd1);
    check("wr_resume_wrap", 32'(wrap16), 32'd0);

    // Sticky overflow: set by wrap, held through 20 counts, cleared by load.
    step(1'b0, 1'b1, 1'b1, 4'd14);
    check("ovf_load14", 32'(ovf16), 32'd0);
    step(1'b1, 1'b1, 1'b0, 4'd0);
    check("ovf_at15", 32'(ovf16), 32'd0);
    step(1'b1, 1'b1, 1'b0, 4'd0);
    check("ovf_set", 32'(ovf16), 32'(STICKY));
    for (int k = 1; k <= 20; k++) begin
      step(1'b1, 1'b1, 1'b0, 4'd0);
      check($sformatf("ovf_hold%0d", k), 32'(ovf16), 32'(STICKY));
    end
    check("ovf_q_after20", 32'(q16), 32'd4);
    step(1'b0, 1'b1, 1'b1, 4'd15);
    check("ovf_load_clr", 32'(ovf16), 32'd0);
    // Load coinciding with a wrap condition: load wins, no wrap, no ovf.
    step(1'b1, 1'b1, 1'b1, 4'd3);
    check("lw_q", 32'(q16), 32'd3);
    check("lw_wrap", 32'(wrap16), 32'd0);
    check("lw_ovf", 32'(ovf16), 32'd0);

    // Down wrap on the full-range modulus: 0 -> 15.
    step(1'b0, 1'b0, 1'b1, 4'd0);
    check("dn_tc_at0", 32'(tc16), 32'd1);
    step(1'b1, 1'b0, 1'b0, 4'd0);
    check("dn_q15", 32'(q16), 32'd15);
    check("dn_wrap", 32'(wrap16), 32'd1);
    check("dn_ovf", 32'(ovf16), 32'(STICKY));
    check("ovf10_idle", 32'(ovf10), 32'(STICKY & 1'b0) | 32'(ovf10 & ~STICKY) | 32'(STICKY & ovf10));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
